// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: shares one external NOR-type SR latch between two requesters.
// Drives fixed-width set/reset pulses (never both), waits for the latch to settle,
// reads it back through a 2-flop synchronizer, acks the requester and flags mismatches.
module sr_latch_ctrl #(
  parameter int unsigned PULSE_CYC = 2,  // 1..255
  parameter int unsigned RECOV_CYC = 2   // 2..255, covers synchronizer latency
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic op0,
  output logic ack0,
  input  logic req1,
  input  logic op1,
  output logic ack1,
  input  logic q,
  output logic s,
  output logic r,
  output logic busy,
  output logic err
);

  localparam logic [7:0] PulseLoad = 8'(PULSE_CYC);
  localparam logic [7:0] RecovLoad = 8'(RECOV_CYC);

  typedef enum logic [1:0] {StIdle, StPulse, StRecov, StCheck} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       op_q, op_d;
  logic       gnt_q, gnt_d;    // granted requester of the current operation
  logic       last_q, last_d;  // round-robin pointer: last granted requester
  logic       err_q, err_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       busy_q, busy_d;
  logic [1:0] sync_q;
  logic       q_sync;
  logic       grant_sel;

  assign q_sync = sync_q[1];

  // On contention pick the requester that was not served last; a lone request always wins.
  assign grant_sel = (req0 && req1) ? ~last_q : req1;

  // Two-flop synchronizer for the asynchronous latch feedback.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], q};
    end
  end

  // Next-state logic plus next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          gnt_d   = grant_sel;
          last_d  = grant_sel;
          op_d    = grant_sel ? op1 : op0;
          cnt_d   = PulseLoad;
          state_d = StPulse;
        end
      end
      StPulse: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = RecovLoad;
          state_d = StRecov;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StRecov: begin
        if (cnt_q <= 8'd1) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StCheck: begin
        if (q_sync != op_q) begin
          err_d = 1'b1;
        end
        state_d = StIdle;
      end
    endcase

    // Outputs are registered one cycle behind the state that produces them.
    s_d    = (state_q == StPulse) && op_q;
    r_d    = (state_q == StPulse) && !op_q;
    ack0_d = (state_q == StCheck) && !gnt_q;
    ack1_d = (state_q == StCheck) && gnt_q;
    busy_d = (state_q != StIdle);
  end

  // State and output registers; reset aborts any operation without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      op_q    <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign s    = s_q;
  assign r    = r_q;
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Self-checking bench for sr_latch_ctrl: directed scenarios plus a randomized stream
// compared against a timeline model of the request/pulse/ack schedule.
module tb_sr_latch_ctrl;

  localparam int unsigned P1 = 2;
  localparam int unsigned R1 = 2;
  localparam int unsigned P2 = 1;
  localparam int unsigned R2 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // DUT A (default timing)
  logic req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
  logic ack0, ack1, s, r, busy, err, q;
  // DUT B (PULSE_CYC=1, RECOV_CYC=3), only requester 1 used
  logic b_req1 = 1'b0, b_op1 = 1'b0;
  logic b_ack0, b_ack1, b_s, b_r, b_busy, b_err, b_q;

  // Behavioural NOR latches standing in for the gate-level cell
  logic lat_a = 1'b0, lat_b = 1'b0;
  logic fault_en = 1'b0, fault_val = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int inv_bad = 0;

  always #5 clk = ~clk;

  always @(s or r) begin
    if (s && !r) lat_a <= 1'b1;
    else if (r && !s) lat_a <= 1'b0;
  end
  always @(b_s or b_r) begin
    if (b_s && !b_r) lat_b <= 1'b1;
    else if (b_r && !b_s) lat_b <= 1'b0;
  end
  assign q   = fault_en ? fault_val : lat_a;
  assign b_q = lat_b;

  // Mutual-exclusion invariants watched on every cycle of every test
  always @(negedge clk) begin
    if ((s && r) || (ack0 && ack1) || (b_s && b_r) || (b_ack0 && b_ack1))
      inv_bad <= inv_bad + 1;
  end

  sr_latch_ctrl #(.PULSE_CYC(P1), .RECOV_CYC(R1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .ack0(ack0),
    .req1(req1), .op1(op1), .ack1(ack1),
    .q(q), .s(s), .r(r), .busy(busy), .err(err)
  );

  sr_latch_ctrl #(.PULSE_CYC(P2), .RECOV_CYC(R2)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(1'b0), .op0(1'b0), .ack0(b_ack0),
    .req1(b_req1), .op1(b_op1), .ack1(b_ack1),
    .q(b_q), .s(b_s), .r(b_r), .busy(b_busy), .err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output vectors are ordered {s, r, ack0, ack1, busy, err}
  task automatic test_reset();
    logic [11:0] got;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req0 = 1'($urandom); op0 = 1'($urandom);
      req1 = 1'($urandom); op1 = 1'($urandom);
      tick();
      got = {s, r, ack0, ack1, busy, err, b_s, b_r, b_ack0, b_ack1, b_busy, b_err};
      n_cmp++;
      if (got !== 12'd0) begin
        n_bad++;
        $display("FAIL reset k=%0d got %012b exp %012b", k, got, 12'd0);
      end
    end
    req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      got = {s, r, ack0, ack1, busy, err, b_s, b_r, b_ack0, b_ack1, b_busy, b_err};
      n_cmp++;
      if (got !== 12'd0) begin
        n_bad++;
        $display("FAIL reset_release k=%0d got %012b exp %012b", k, got, 12'd0);
      end
    end
  endtask

  task automatic test_contention();
    logic [5:0] got, exp;
    req0 = 1'b1; op0 = 1'b1; req1 = 1'b1; op1 = 1'b0;
    tick();  // grant edge t
    for (int k = 1; k <= 12; k++) begin
      tick();
      got = {s, r, ack0, ack1, busy, err};
      exp = {k <= 2, k == 7 || k == 8, k == 5, k == 11, k <= 5 || (k >= 7 && k <= 11), 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL contention k=%0d got %06b exp %06b", k, got, exp);
      end
      if (k == 5) req0 = 1'b0;
      if (k == 11) req1 = 1'b0;
    end
    n_cmp++;
    if (q !== 1'b0) begin
      n_bad++;
      $display("FAIL contention_latch got %b exp 0", q);
    end
  endtask

  task automatic test_single_set();
    logic [5:0] got, exp;
    req0 = 1'b1; op0 = 1'b1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      got = {s, r, ack0, ack1, busy, err};
      exp = {k <= 2, 1'b0, k == 5, 1'b0, k <= 5, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL single_set k=%0d got %06b exp %06b", k, got, exp);
      end
      if (k == 5) req0 = 1'b0;
    end
    n_cmp++;
    if (q !== 1'b1) begin
      n_bad++;
      $display("FAIL single_set_latch got %b exp 1", q);
    end
  endtask

  task automatic test_readback_fault();
    logic [5:0] got, exp;
    fault_en = 1'b1; fault_val = 1'b0;
    req1 = 1'b1; op1 = 1'b1;
    tick();
    for (int k = 1; k <= 25; k++) begin
      tick();
      got = {s, r, ack0, ack1, busy, err};
      exp = {k <= 2, 1'b0, 1'b0, k == 5, k <= 5, k >= 5};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL readback_fault k=%0d got %06b exp %06b", k, got, exp);
      end
      if (k == 5) req1 = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; fault_en = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL readback_fault_clear err got %b exp 0", err);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [5:0] got, exp;
    req0 = 1'b1; op0 = 1'b1;
    tick();  // grant edge t
    tick();  // t+1
    n_cmp++;
    if ({s, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL mid_pulse_start got s/busy %02b exp 11", {s, busy});
    end
    rst = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      tick();
      if (k == 3) begin
        rst = 1'b0; req0 = 1'b0;
      end
      got = {s, r, ack0, ack1, busy, err};
      n_cmp++;
      if (got !== 6'd0) begin
        n_bad++;
        $display("FAIL mid_pulse_abort k=%0d got %06b exp %06b", k, got, 6'd0);
      end
    end
    req0 = 1'b1; op0 = 1'b0;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      got = {s, r, ack0, ack1, busy, err};
      exp = {1'b0, k <= 2, k == 5, 1'b0, k <= 5, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL mid_pulse_retry k=%0d got %06b exp %06b", k, got, exp);
      end
      if (k == 5) req0 = 1'b0;
    end
    n_cmp++;
    if (q !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_pulse_retry_latch got %b exp 0", q);
    end
  endtask

  task automatic test_alternating();
    logic [5:0] got, exp;
    logic cur_op;
    cur_op = 1'b1;
    b_req1 = 1'b1; b_op1 = cur_op;
    tick();  // first grant edge
    for (int n = 0; n < 8; n++) begin
      for (int ph = 1; ph <= 6; ph++) begin
        tick();
        got = {b_s, b_r, b_ack0, b_ack1, b_busy, b_err};
        exp = {ph == 1 && cur_op, ph == 1 && !cur_op, 1'b0, ph == 5, ph <= 5, 1'b0};
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL alternating n=%0d ph=%0d got %06b exp %06b", n, ph, got, exp);
        end
        if (ph == 5) begin
          n_cmp++;
          if (b_q !== cur_op) begin
            n_bad++;
            $display("FAIL alternating_latch n=%0d got %b exp %b", n, b_q, cur_op);
          end
          cur_op = !cur_op;
          b_op1 = cur_op;
          if (n == 7) b_req1 = 1'b0;
        end
      end
    end
  endtask

  // Random traffic on DUT A against a schedule model: a grant at edge g occupies
  // edges g+1..g+P+R+1, acks at g+P+R+1 and frees the controller from g+P+R+2.
  task automatic test_random();
    logic [5:0] got, exp;
    int   free_at, g, d;
    logic who, cop, last_m, active, err_m, lat_m;
    logic ex_s, ex_r, ex_ack, ex_busy;
    free_at = 0; g = 0; d = 0;
    who = 1'b0; cop = 1'b0; last_m = 1'b1; active = 1'b0; err_m = 1'b0; lat_m = 1'b0;
    ex_ack = 1'b0;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    for (int e = 0; e < 600; e++) begin
      tick();
      if (rst) begin
        active = 1'b0; last_m = 1'b1; err_m = 1'b0; free_at = e + 1;
        exp = 6'd0;
        ex_ack = 1'b0;
      end else begin
        if (e >= free_at && (req0 || req1)) begin
          who     = (req0 && req1) ? !last_m : req1;
          cop     = who ? op1 : op0;
          last_m  = who;
          g       = e;
          free_at = e + int'(P1 + R1 + 2);
          active  = 1'b1;
        end
        d       = e - g;
        ex_s    = active && d >= 1 && d <= int'(P1) && cop;
        ex_r    = active && d >= 1 && d <= int'(P1) && !cop;
        ex_ack  = active && d == int'(P1 + R1 + 1);
        ex_busy = active && d >= 1 && d <= int'(P1 + R1 + 1);
        if (ex_s) lat_m = 1'b1;
        if (ex_r) lat_m = 1'b0;
        if (ex_ack && lat_m != cop) err_m = 1'b1;
        exp = {ex_s, ex_r, ex_ack && !who, ex_ack && who, ex_busy, err_m};
      end
      got = {s, r, ack0, ack1, busy, err};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL random e=%0d got %06b exp %06b", e, got, exp);
      end
      // stimulus for the next edge
      rst = ($urandom_range(0, 99) == 0);
      if (ex_ack && !who) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1'b1; op0 = 1'($urandom);
      end else if (active && !who && d >= 0 && $urandom_range(0, 2) == 0) op0 = !op0;
      if (ex_ack && who) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1'b1; op1 = 1'($urandom);
      end else if (active && who && d >= 0 && $urandom_range(0, 2) == 0) op1 = !op1;
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (inv_bad !== 0) begin
      n_bad++;
      $display("FAIL invariants s&r or ack0&ack1 seen %0d times exp 0", inv_bad);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_set();
    test_readback_fault();
    test_reset_mid_pulse();
    test_alternating();
    test_random();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Synchronous controller that shares one external NOR-type SR latch (`nor_rs`-style, outputs `q`/`qb`) between two requesters. It drives the latch's set/reset inputs with fixed-width pulses and never asserts both together. After each pulse it reads the latch state back through a 2-flop synchronizer, acknowledges the requester, and flags any mismatch. It sits between the clocked control logic and the gate-level latch in the lab datapath.

## Interface

Parameters:
- `PULSE_CYC`, default 2: cycles that `s` or `r` is held high per operation; legal range 1..255.
- `RECOV_CYC`, default 2: cycles with `s`=`r`=0 after a pulse, before readback; legal range 2..255, which covers the synchronizer latency.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req0`  in  1  requester 0 operation request; held until `ack0`.
- `op0`  in  1  requester 0 operation: 1 = set, 0 = reset. Valid while `req0` is high.
- `ack0`  out  1  one-cycle completion pulse to requester 0.
- `req1`, `op1`, `ack1`: same as above, for requester 1.
- `q`  in  1  latch output feedback. Asynchronous; passed through a 2-flop synchronizer to give `q_sync`.
- `s`  out  1  latch set drive.
- `r`  out  1  latch reset drive.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky readback-mismatch flag.

## Operation

- FSM states: IDLE, PULSE, RECOV, CHECK.
- IDLE:
  - If any `req` is high, grant one requester, latch its `op` into `op_q`, load the counter with `PULSE_CYC`, and go to PULSE.
  - Otherwise stay in IDLE.
- Arbitration is round-robin with a 1-bit pointer `last`.
  - If both requests are high, grant the requester not equal to `last`.
  - A single request is granted regardless of `last`.
  - `last` updates on every grant.
- PULSE:
  - `s` = `op_q`, `r` = !`op_q`.
  - Counter decrements each cycle. At count 1, load `RECOV_CYC` and go to RECOV.
- RECOV:
  - `s` = `r` = 0.
  - Counter decrements each cycle. At count 1, go to CHECK.
- CHECK (one cycle):
  - Assert `ack` of the granted requester.
  - If `q_sync` != `op_q`, set `err`. `ack` is still issued on a mismatch.
  - Go to IDLE.
- Handshake:
  - The requester holds `req` and `op` stable until `ack`.
  - The requester drops `req` on the cycle after `ack`.
  - Because the FSM spends one cycle in IDLE after CHECK, a dropping `req` is never re-granted.
- `s`, `r`, and `ack0`/`ack1` are registered outputs.
- Invariant: `s` && `r` is never 1. `ack0` && `ack1` is never 1.
- Changes to `op` during an operation are ignored; `op_q` is captured at grant.
- Counter width is 8 bits.
- `err` clears only on `rst`.
- No redundancy skip: a set on an already-set latch still runs the full sequence.

## Timing

- Reset values, applied on the first rising edge with `rst`=1:
  - state = IDLE; `s` = `r` = 0; `ack0` = `ack1` = 0; `busy` = 0; `err` = 0.
  - `last` = 1, so `req0` wins the first contention.
  - Synchronizer flops = 0.
- `rst` asserted mid-operation, in any state:
  - Next edge returns to IDLE with `s` = `r` = 0.
  - No `ack` is issued; the requester must re-request.
- Latency, for a request sampled in IDLE at edge t:
  - `s`/`r` high for edges t+1 .. t+`PULSE_CYC`.
  - Both low for the next `RECOV_CYC` cycles.
  - `ack` high at t+`PULSE_CYC`+`RECOV_CYC`+1. With defaults this is t+5.
- `err` rises in the same cycle as the offending `ack`.
- Back-to-back throughput: one operation per `PULSE_CYC`+`RECOV_CYC`+2 cycles. With defaults this is 6.
- `busy` rises at t+1 and falls in the cycle after CHECK.

## Test plan

- Reset: hold `rst` for 2 cycles with random `req`/`op` -> `s` = `r` = `ack0` = `ack1` = `busy` = `err` = 0 throughout; state is IDLE after release.
- Single set: `req0`=1, `op0`=1 sampled at t, gate-level latch attached -> `s`=1 at t+1 and t+2, `r`=0 throughout, `ack0`=1 only at t+5, `err`=0, latch `q`=1.
- Contention: `req0`=`req1`=1 (`op0`=1, `op1`=0) at t right after reset -> requester 0 served first (`ack0` at t+5). `r` pulse for requester 1 at t+7..t+8, `ack1` at t+11. `s`&`r` never 1.
- Readback fault: `q` forced to 0, `req1`/`op1`=1 -> `ack1` still issued at t+5, `err`=1 from t+5 and held through 20 idle cycles; cleared by `rst`.
- Reset mid-pulse: `rst` asserted at t+1 of a set operation -> `s`=0 at t+2, no `ack0`, `busy`=0. A fresh request afterwards completes normally.
- Alternating stream: `req1` held with `op1` toggling after every `ack`, 8 operations, `PULSE_CYC`=1, `RECOV_CYC`=3 -> `ack` period 6 cycles, latch `q` tracks `op1`, `s`&`r` never 1, `err`=0.
